instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly downstream of the 12-bit program counter. On request from the control unit it captures the current PC value, issues a single read to the synchronous instruction memory, pulses the PC increment enable, and loads the returned word into the instruction register (IR) with a one-cycle valid strobe. It supports a configurable memory read latency and a flush input for jumps and branches.

## Interface

- ADDR_W, 12, instruction address width; matches the PC output width.
- INSTR_W, 8, instruction word width.
- MEM_LATENCY, 1, cycles from the edge sampling `imem_rd_en` to the edge at which `imem_rdata` is valid; legal range 1..4.

- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- fetch_req  input  1  control unit requests one instruction fetch; sampled only in IDLE.
- flush  input  1  abort any in-flight fetch; highest priority after reset.
- pc_addr  input  ADDR_W  current PC value.
- pc_inc_en  output  1  one-cycle pulse to the PC's increment enable.
- imem_addr  output  ADDR_W  registered instruction memory address.
- imem_rd_en  output  1  one-cycle read strobe to instruction memory.
- imem_rdata  input  INSTR_W  instruction memory read data.
- ir  output  INSTR_W  instruction register; holds its value until the next completed fetch.
- ir_valid  output  1  one-cycle pulse in the cycle `ir` is updated.
- busy  output  1  fetch in progress; new requests are ignored while high.

## Operation

- Reset (rst_n=0 at an edge): state IDLE, wait counter 0, ir=0, ir_valid=0, imem_addr=0, imem_rd_en=0, pc_inc_en=0, busy=0. Reset overrides every other input.
- States:
  - **IDLE**: busy=0. fetch_req=1 and flush=0 at an edge → capture `pc_addr` into `imem_addr`; next cycle imem_rd_en=1, pc_inc_en=1; go to READ.
  - **READ**: one cycle, strobes high. The wait counter loads MEM_LATENCY-1. If MEM_LATENCY=1 → LATCH, else → WAIT.
  - **WAIT**: decrement the counter each cycle; at 1 → LATCH.
  - **LATCH**: at the edge ending this state, ir <= imem_rdata, ir_valid=1 in the following cycle; → IDLE.
- Precedence within a cycle: reset, then flush, then normal transition.
- imem_rd_en and pc_inc_en are high for exactly one cycle per accepted request. No other cycle asserts them.
- The PC increments before the IR loads, so `pc_addr` already points to the next instruction when ir_valid is high.
- flush=1 at an edge in READ, WAIT or LATCH:
  - Go to IDLE and clear the counter.
  - ir is unchanged and no ir_valid is generated for that fetch.
  - The pc_inc_en already issued is not retracted; the jump overwrites the PC.
- flush=1 together with fetch_req in IDLE: the request is dropped.
- fetch_req while busy=1: ignored, not queued. The control unit must re-assert it.
- Address wrap-around is the PC's responsibility. `imem_addr` is a pure capture with no arithmetic.
- imem_rdata is ignored in every state except LATCH.

## Timing

- Request sampled at edge E0, meaning fetch_req is high in cycle 0.
- Cycle 1: imem_rd_en=1, pc_inc_en=1, imem_addr=captured PC, busy=1.
- Cycle 2: the PC shows PC+1.
- Memory data is sampled at edge E(1+MEM_LATENCY).
- ir and ir_valid are updated in cycle 2+MEM_LATENCY, with busy=0 in that cycle.
- busy is high in cycles 1 through 1+MEM_LATENCY.
- Back-to-back: fetch_req high in the ir_valid cycle is accepted and captures the incremented PC. Throughput is one instruction per MEM_LATENCY+2 cycles.
- Latency from request to ir_valid: MEM_LATENCY+2 cycles (3 with the default).

## Test plan

- **Reset**: hold rst_n=0 for 2 cycles with fetch_req=1 → all outputs 0 and no strobes; the first request after release behaves normally.
- **Single fetch, MEM_LATENCY=1**: pc_addr=12'h005, fetch_req pulse in cycle 0, memory returns 8'hA3 in cycle 2.
  - Cycle 1: imem_addr=12'h005, imem_rd_en=1, pc_inc_en=1.
  - Cycle 3: ir=8'hA3, ir_valid=1.
- **Back-to-back**: fetch_req held high, PC model starting at 12'h0FF.
  - Addresses 12'h0FF, 12'h100, 12'h101 are issued 3 cycles apart.
  - One ir_valid per fetch, each with the matching data.
- **Busy drop**: a fetch_req pulse in cycle 2 of an active fetch → no extra imem_rd_en or pc_inc_en, and only one ir_valid.
- **Flush mid-WAIT (MEM_LATENCY=3)**: flush in cycle 2 → no ir_valid, ir keeps its old value, busy=0 in cycle 3; a new request in cycle 3 succeeds.
- **Reset mid-fetch**: rst_n=0 in the READ cycle → no ir_valid and ir=0; the state returns to IDLE.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction memory read port shared by the fetch stage (master) and the
// synchronous instruction memory (slave).
interface instr_fetch_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 8
);
  logic [ADDR_W-1:0]  addr;
  logic               rd_en;
  logic [INSTR_W-1:0] rdata;

  modport master (output addr, output rd_en, input rdata);
  modport slave  (input addr, input rd_en, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: captures the PC on request, issues one read to the
// synchronous instruction memory, pulses the PC increment and loads the
// returned word into the instruction register with a one-cycle valid strobe.
module instr_fetch #(
  parameter int ADDR_W      = 12,
  parameter int INSTR_W     = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_inc_en,
  instr_fetch_if.master      imem,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_LATCH} state_t;

  // Latency is limited to 1..4, so the residual wait count fits in two bits.
  localparam logic [1:0] CNT_LOAD = 2'(MEM_LATENCY - 1);

  state_t     state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic       capture;
  logic       load_ir;

  // State register and memory wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; flush wins over every normal transition.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    load_ir  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_req && !flush) begin
          capture  = 1'b1;
          state_nx = S_READ;
        end
      end
      S_READ: begin
        if (flush) begin
          state_nx = S_IDLE;
          cnt_nx   = 2'd0;
        end else begin
          cnt_nx   = CNT_LOAD;
          state_nx = (MEM_LATENCY == 1) ? S_LATCH : S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_nx = S_IDLE;
          cnt_nx   = 2'd0;
        end else begin
          cnt_nx = cnt - 2'd1;
          if (cnt == 2'd1) state_nx = S_LATCH;
        end
      end
      S_LATCH: begin
        state_nx = S_IDLE;
        cnt_nx   = 2'd0;
        // A flushed fetch leaves the IR untouched and raises no valid.
        load_ir  = !flush;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  // Address capture, instruction register and its one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem.addr <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
    end else begin
      ir_valid <= load_ir;
      if (capture) imem.addr <= pc_addr;
      if (load_ir) ir <= imem.rdata;
    end
  end

  // READ lasts exactly one cycle, so both strobes pulse once per fetch.
  assign imem.rd_en = (state == S_READ);
  assign pc_inc_en  = (state == S_READ);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (memory latency 1 and 3) driven with
// the same control stimulus, each with its own PC, memory and reference model.
module tb_instr_fetch;
  localparam int AW = 12;
  localparam int IW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, req, flush;
  logic [AW-1:0] pc    [2];
  logic [AW-1:0] pc_nx [2];
  logic [IW-1:0] rdata [2];
  logic          inc   [2];
  logic          rd    [2];
  logic          busy  [2];
  logic          irv   [2];
  logic [AW-1:0] iaddr [2];
  logic [IW-1:0] ir    [2];

  instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus0 ();
  instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus1 ();
  assign rd[0]      = bus0.rd_en;
  assign iaddr[0]   = bus0.addr;
  assign bus0.rdata = rdata[0];
  assign rd[1]      = bus1.rd_en;
  assign iaddr[1]   = bus1.addr;
  assign bus1.rdata = rdata[1];

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .MEM_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .fetch_req(req), .flush(flush),
    .pc_addr(pc[0]), .pc_inc_en(inc[0]), .imem(bus0.master),
    .ir(ir[0]), .ir_valid(irv[0]), .busy(busy[0]));

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .MEM_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .fetch_req(req), .flush(flush),
    .pc_addr(pc[1]), .pc_inc_en(inc[1]), .imem(bus1.master),
    .ir(ir[1]), .ir_valid(irv[1]), .busy(busy[1]));

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Shared instruction memory contents and per-instance read scheduling.
  logic [IW-1:0] mem [4096];
  int            due   [2];
  logic [AW-1:0] daddr [2];

  // Transaction-level reference: a fetch is "active" for cycles 1..1+L after
  // the accepting edge; k is the cycle number inside the current fetch.
  bit            m_act [2];
  int            m_k   [2];
  logic [AW-1:0] m_addr[2];
  logic [IW-1:0] m_ir  [2];
  bit            m_val [2];

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  bit  armed = 0;
  int  nval [2];
  int  nrd  [2];
  logic [AW-1:0] q_addr [$];
  int            q_cyc  [$];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive memory data, compare outputs, advance the models.
  task automatic tick();
    for (int i = 0; i < 2; i++)
      rdata[i] = (due[i] == cyc) ? mem[daddr[i]] : IW'($urandom);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (armed) begin
        check_eq($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_act[i]));
        check_eq($sformatf("rd_en%0d", i), 32'(rd[i]), 32'(m_act[i] && m_k[i] == 1));
        check_eq($sformatf("pc_inc%0d", i), 32'(inc[i]), 32'(m_act[i] && m_k[i] == 1));
        check_eq($sformatf("imem_addr%0d", i), 32'(iaddr[i]), 32'(m_addr[i]));
        check_eq($sformatf("ir%0d", i), 32'(ir[i]), 32'(m_ir[i]));
        check_eq($sformatf("ir_valid%0d", i), 32'(irv[i]), 32'(m_val[i]));
      end
      if (irv[i] === 1'b1) nval[i]++;
      if (rd[i] === 1'b1) begin
        nrd[i]++;
        due[i]   = cyc + lat(i);
        daddr[i] = iaddr[i];
        if (i == 0) begin
          q_addr.push_back(iaddr[0]);
          q_cyc.push_back(cyc);
        end
      end
      // External PC: a jump accompanies a flush, otherwise it counts on pc_inc_en.
      if (flush) pc_nx[i] = AW'($urandom);
      else if (inc[i] === 1'b1) pc_nx[i] = pc[i] + 1'b1;
      else pc_nx[i] = pc[i];
      // Reference model update for the edge ending this cycle.
      m_val[i] = 0;
      if (!rst_n) begin
        m_act[i] = 0; m_k[i] = 0; m_addr[i] = '0; m_ir[i] = '0;
      end else if (m_act[i]) begin
        if (flush) m_act[i] = 0;
        else if (m_k[i] == 1 + lat(i)) begin
          m_ir[i] = mem[m_addr[i]]; m_val[i] = 1; m_act[i] = 0;
        end else m_k[i]++;
      end else if (req && !flush) begin
        m_act[i] = 1; m_k[i] = 1; m_addr[i] = pc[i];
      end
    end
    if (!rst_n) armed = 1;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) pc[i] = pc_nx[i];
  endtask

  task automatic idle_ticks(int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  int            v0 [2];
  int            r0 [2];
  logic [IW-1:0] ir_keep;

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = IW'($urandom);
    for (int i = 0; i < 2; i++) begin
      due[i] = -1; daddr[i] = '0; pc[i] = '0; rdata[i] = '0;
      m_act[i] = 0; m_k[i] = 0; m_addr[i] = '0; m_ir[i] = '0; m_val[i] = 0;
      nval[i] = 0; nrd[i] = 0;
    end
    rst_n = 1'b0; req = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a pending request: nothing may start.
    idle_ticks(2);
    check_eq("reset_busy", 32'(busy[0] | busy[1]), 32'd0);
    check_eq("reset_strobes", 32'(nrd[0] + nrd[1]), 32'd0);
    rst_n = 1'b1; req = 1'b0;
    tick();

    // Single fetch from 0x005 returning 0xA3.
    mem[12'h005] = 8'hA3;
    pc[0] = 12'h005; pc[1] = 12'h005;
    req = 1'b1; tick();
    req = 1'b0;
    check_eq("single_addr0", 32'(iaddr[0]), 32'h005);
    check_eq("single_rd0", 32'(rd[0]), 32'd1);
    idle_ticks(6);
    check_eq("single_ir0", 32'(ir[0]), 32'hA3);
    check_eq("single_ir1", 32'(ir[1]), 32'hA3);

    // Back-to-back with the PC starting at 0x0FF.
    pc[0] = 12'h0FF; pc[1] = 12'h0FF;
    q_addr.delete(); q_cyc.delete();
    v0[0] = nval[0];
    req = 1'b1; idle_ticks(15);
    req = 1'b0; idle_ticks(6);
    check_eq("b2b_n", 32'(q_addr.size() >= 3), 32'd1);
    check_eq("b2b_a0", 32'(q_addr[0]), 32'h0FF);
    check_eq("b2b_a1", 32'(q_addr[1]), 32'h100);
    check_eq("b2b_a2", 32'(q_addr[2]), 32'h101);
    check_eq("b2b_gap1", 32'(q_cyc[1] - q_cyc[0]), 32'd3);
    check_eq("b2b_gap2", 32'(q_cyc[2] - q_cyc[1]), 32'd3);
    check_eq("b2b_valids", 32'(nval[0] - v0[0]), 32'(q_addr.size()));

    // Request pulse during an active fetch is dropped.
    for (int i = 0; i < 2; i++) begin v0[i] = nval[i]; r0[i] = nrd[i]; end
    req = 1'b1; tick();
    req = 1'b0; tick();
    req = 1'b1; tick();
    req = 1'b0; idle_ticks(6);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("drop_rd%0d", i), 32'(nrd[i] - r0[i]), 32'd1);
      check_eq($sformatf("drop_val%0d", i), 32'(nval[i] - v0[i]), 32'd1);
    end

    // Flush in cycle 2 (WAIT for latency 3, LATCH for latency 1).
    for (int i = 0; i < 2; i++) v0[i] = nval[i];
    ir_keep = ir[1];
    req = 1'b1; tick();
    req = 1'b0; tick();
    flush = 1'b1; tick();
    flush = 1'b0;
    check_eq("flush_busy1", 32'(busy[1]), 32'd0);
    check_eq("flush_ir1", 32'(ir[1]), 32'(ir_keep));
    req = 1'b1; tick();
    req = 1'b0; idle_ticks(6);
    check_eq("flush_val0", 32'(nval[0] - v0[0]), 32'd1);
    check_eq("flush_val1", 32'(nval[1] - v0[1]), 32'd1);

    // Reset asserted in the READ cycle.
    for (int i = 0; i < 2; i++) v0[i] = nval[i];
    req = 1'b1; tick();
    req = 1'b0; rst_n = 1'b0; tick();
    rst_n = 1'b1; idle_ticks(6);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rstmid_val%0d", i), 32'(nval[i] - v0[i]), 32'd0);
      check_eq($sformatf("rstmid_ir%0d", i), 32'(ir[i]), 32'd0);
    end

    // Randomized traffic with occasional flushes and resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      req   = $urandom_range(0, 1) == 1;
      flush = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
